mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 16x8 synchronous memory, which has a registered output enabled by its read strobe.
- Lets two requesters (port 0: instruction fetch, port 1: data load/store) share that one memory.
- Runs one transaction at a time: latch a request, drive the memory for exactly the required cycles, capture read data after the fixed read latency, then return a one-cycle ack to the winning port.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 2, cycles from the address being sampled by the memory to valid output data; legal range 1..7.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, ack1: same meanings for port 1.
- rdata  out  DATA_W  last captured read data; valid in a read's ack cycle, held until the next read completes.
- busy  out  1  high whenever the state is not IDLE.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory output-register enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; ack0=ack1=0; busy=0.
  - mem_write=mem_read=0; mem_addr=0; mem_wdata=0; rdata=0.
  - last_gnt=1, so port 0 wins the first contention.
  - The counter clears.
- Reset mid-transaction aborts it with no ack. A write aborted in ISSUE may or may not reach the memory.
- All outputs are registered.
- IDLE:
  - If no request, stay.
  - If only one request, grant that port.
  - If both request, grant the port other than last_gnt.
  - Latch gnt, we, addr and wdata from the granted port; go to ISSUE.
  - Request inputs are not sampled in any other state.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched addr.
  - Write: mem_write=1, mem_wdata = latched data; go to DONE.
  - Read: mem_read=1; counter=RD_LAT; go to WAIT.
- WAIT:
  - mem_read stays 1; mem_write=0; mem_addr held.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, rdata <= mem_rdata at the end of that cycle; go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE (exactly 1 cycle):
  - mem_write=mem_read=0.
  - ack of the granted port =1, the other ack =0.
  - last_gnt <= granted port; go to IDLE.
- Latency, with the request seen in IDLE at cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT (cycle 4 at the default).
- Throughput: a port holding req continuously gets back-to-back transactions every 3 (write) or 3+RD_LAT (read) cycles.
  - Under contention the ports strictly alternate.
- Requester rules:
  - A requester may deassert req in its ack cycle or later.
  - req high in the IDLE cycle after ack starts a new transaction.
  - Changes to we/addr/wdata after the IDLE latch are ignored.
- mem_write and mem_read are never high in the same cycle.
- ack0 and ack1 are never high together.
- rdata is unchanged by writes.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5 -> mem_write=1 with mem_addr=3 and mem_wdata=0xA5 in cycle 1 only; ack0=1 in cycle 2; busy high in cycles 1–2.
- Port 1 read addr 3 after that write (RD_LAT=2, behavioural memory model) -> mem_read high in cycles 1–3; ack1 in cycle 4; rdata=0xA5, held through later writes.
- req0 and req1 both held high as reads for 4 transactions -> grants in order 0,1,0,1; acks 5 cycles apart; no ack overlap.
- Boundary addresses: write 0x00 to addr 15, then 0xFF to addr 0; read both back -> 0x00 and 0xFF. Check no address wrap or corruption.
- Assert rst during WAIT of a read -> all outputs 0 immediately (asynchronous); no ack. After release, req1 alone is granted within 1 cycle, and port 0 wins the next contention.
- RD_LAT=1 build: a read acks in cycle 3 with correct data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the memory-side bus
// of mem_arbiter.
//   req0/we0/addr0/wdata0/ack0 : port 0 (instruction fetch) handshake
//   req1/we1/addr1/wdata1/ack1 : port 1 (data load/store) handshake
//   rdata, busy                : shared read result and activity flag
//   mem_write/mem_read/mem_addr/mem_wdata/mem_rdata : single-port memory bus
// Modports:
//   master : the arbiter's view (drives acks, rdata, busy and memory controls)
//   slave  : the environment's view (requesters plus the memory)
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata, busy,
        output mem_write, mem_read, mem_addr, mem_wdata
    );

    modport slave (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata, busy,
        input  mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer in front of a
// single-port synchronous memory whose output register is enabled by its
// read strobe. One transaction at a time: IDLE latches the winning request,
// ISSUE drives the memory for one cycle, WAIT covers the RD_LAT read latency,
// DONE pulses the winner's ack for one cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : mem_arbiter_if.master (requester handshakes, rdata, busy, memory bus)
// Parameters: ADDR_W / DATA_W memory widths, RD_LAT read latency (1..7).
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state;
    logic              gnt;        // port owning the current transaction
    logic              we_l;       // latched write flag of that port
    logic              last_gnt;   // port served by the previous transaction
    logic [2:0]        cnt;

    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    // Under contention the port not served last wins; a lone request wins.
    always_comb begin
        pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_gnt;
        end
        pick_we    = pick ? bus.we1    : bus.we0;
        pick_addr  = pick ? bus.addr1  : bus.addr0;
        pick_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    // Outputs are registered on the edge that enters the state they belong
    // to, so each state's memory controls and ack are visible during it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            we_l          <= 1'b0;
            last_gnt      <= 1'b1;
            cnt           <= '0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt          <= pick;
                        we_l         <= pick_we;
                        bus.busy     <= 1'b1;
                        bus.mem_addr <= pick_addr;
                        if (pick_we) begin
                            bus.mem_write <= 1'b1;
                            bus.mem_wdata <= pick_wdata;
                        end else begin
                            bus.mem_read <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_l) begin
                        bus.mem_write <= 1'b0;
                        bus.ack0      <= ~gnt;
                        bus.ack1      <= gnt;
                        state         <= DONE;
                    end else begin
                        cnt   <= LAT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        bus.rdata    <= bus.mem_rdata;
                        bus.mem_read <= 1'b0;
                        bus.ack0     <= ~gnt;
                        bus.ack1     <= gnt;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    last_gnt <= gnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Two instances are
// built, one at RD_LAT=2 (bus_a) and one at RD_LAT=1 (bus_b); 'sel' routes
// requests to one of them and muxes its outputs for observation. Each has a
// behavioural memory whose output pipeline depth equals its read latency.
// Expected values come from a reference memory array, the last read value,
// the last granted port, and latency formulas for each transaction type.
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk;
    logic rst;
    logic mem_clr;
    logic sel;

    logic          req0_d, we0_d, req1_d, we1_d;
    logic [AW-1:0] addr0_d, addr1_d;
    logic [DW-1:0] wdata0_d, wdata1_d;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    assign bus_a.req0   = req0_d & ~sel;
    assign bus_b.req0   = req0_d & sel;
    assign bus_a.req1   = req1_d & ~sel;
    assign bus_b.req1   = req1_d & sel;
    assign bus_a.we0    = we0_d;
    assign bus_b.we0    = we0_d;
    assign bus_a.we1    = we1_d;
    assign bus_b.we1    = we1_d;
    assign bus_a.addr0  = addr0_d;
    assign bus_b.addr0  = addr0_d;
    assign bus_a.addr1  = addr1_d;
    assign bus_b.addr1  = addr1_d;
    assign bus_a.wdata0 = wdata0_d;
    assign bus_b.wdata0 = wdata0_d;
    assign bus_a.wdata1 = wdata1_d;
    assign bus_b.wdata1 = wdata1_d;

    logic          o_ack0, o_ack1, o_busy, o_mem_write, o_mem_read;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_rdata;
    assign o_ack0      = sel ? bus_b.ack0      : bus_a.ack0;
    assign o_ack1      = sel ? bus_b.ack1      : bus_a.ack1;
    assign o_busy      = sel ? bus_b.busy      : bus_a.busy;
    assign o_mem_write = sel ? bus_b.mem_write : bus_a.mem_write;
    assign o_mem_read  = sel ? bus_b.mem_read  : bus_a.mem_read;
    assign o_mem_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
    assign o_mem_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
    assign o_rdata     = sel ? bus_b.rdata     : bus_a.rdata;

    // Behavioural memories: writes land on the edge, reads go through an
    // output pipeline clocked only while mem_read is high.
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (bus_a.mem_write) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            if (bus_b.mem_write) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
        if (bus_a.mem_read) begin
            pa0 <= mem_a[bus_a.mem_addr];
            pa1 <= pa0;
        end
        if (bus_b.mem_read) pb0 <= mem_b[bus_b.mem_addr];
    end
    assign bus_a.mem_rdata = pa1;
    assign bus_b.mem_rdata = pb0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state, indexed by instance (0: RD_LAT=2, 1: RD_LAT=1).
    logic [DW-1:0] ref_mem [2][16];
    logic [DW-1:0] ref_rdata [2];
    logic          model_last [2];

    int tests = 0;
    int fails = 0;

    // Observations collected by the drivers.
    int            r_ack;
    int            r_wmask, r_rmask, r_bmask;
    logic          r_busok, r_stray;
    logic [DW-1:0] r_rd;
    int            c_cnt;
    logic          c_overlap;
    int            c_port [8];
    int            c_cyc  [8];
    logic [DW-1:0] c_rd   [8];

    function automatic int lat_of(input logic s);
        return s ? 1 : 2;
    endfunction
    function automatic int exp_ack(input logic we, input int l);
        return we ? 2 : 2 + l;
    endfunction
    function automatic int exp_wmask(input logic we);
        return we ? 32'h2 : 32'h0;
    endfunction
    function automatic int exp_rmask(input logic we, input int l);
        return we ? 0 : (((1 << (l + 1)) - 1) << 1);
    endfunction
    function automatic int exp_bmask(input logic we, input int l);
        return ((1 << exp_ack(we, l)) - 1) << 1;
    endfunction

    // Applies to the reference model the effect of a completed transaction.
    task automatic model_commit(input logic port, input logic we,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (we) ref_mem[sel][addr] = data;
        else    ref_rdata[sel] = ref_mem[sel][addr];
        model_last[sel] = port;
    endtask

    // Single-port transaction, called at a negedge of an IDLE cycle (cycle 0).
    // Records strobes per cycle, the ack cycle, and rdata in the ack cycle.
    task automatic run_txn(input logic port, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        r_ack = -1; r_wmask = 0; r_rmask = 0; r_bmask = 0;
        r_busok = 1'b1; r_stray = 1'b0; r_rd = '0;
        if (!port) begin
            req0_d = 1'b1; we0_d = we; addr0_d = addr; wdata0_d = data;
        end else begin
            req1_d = 1'b1; we1_d = we; addr1_d = addr; wdata1_d = data;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Post-latch changes must not affect the transaction.
                if (!port) begin
                    we0_d = 1'($urandom); addr0_d = AW'($urandom); wdata0_d = DW'($urandom);
                end else begin
                    we1_d = 1'($urandom); addr1_d = AW'($urandom); wdata1_d = DW'($urandom);
                end
            end
            if (o_mem_write) begin
                r_wmask |= (1 << k);
                if (o_mem_addr !== addr || o_mem_wdata !== data) r_busok = 1'b0;
            end
            if (o_mem_read) begin
                r_rmask |= (1 << k);
                if (o_mem_addr !== addr) r_busok = 1'b0;
            end
            if (o_mem_write && o_mem_read) r_busok = 1'b0;
            if (o_busy) r_bmask |= (1 << k);
            if (r_ack >= 0) begin
                if (o_ack0 || o_ack1) r_stray = 1'b1;
                break;
            end
            if ((port ? o_ack0 : o_ack1) === 1'b1) r_stray = 1'b1;
            if ((port ? o_ack1 : o_ack0) === 1'b1) begin
                r_ack = k;
                r_rd = o_rdata;
                req0_d = 1'b0;
                req1_d = 1'b0;
            end
        end
        req0_d = 1'b0;
        req1_d = 1'b0;
    endtask

    // Both ports hold read requests until n acks have been seen in total.
    task automatic run_both(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        c_cnt = 0; c_overlap = 1'b0;
        req0_d = 1'b1; we0_d = 1'b0; addr0_d = a0;
        req1_d = 1'b1; we1_d = 1'b0; addr1_d = a1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (o_ack0 && o_ack1) c_overlap = 1'b1;
            if (c_cnt == n) begin
                if (o_ack0 || o_ack1) c_overlap = 1'b1;
                break;
            end
            if (o_ack0 || o_ack1) begin
                c_port[c_cnt] = o_ack1 ? 1 : 0;
                c_cyc[c_cnt]  = k;
                c_rd[c_cnt]   = o_rdata;
                c_cnt++;
                if (c_cnt == n) begin
                    req0_d = 1'b0;
                    req1_d = 1'b0;
                end
            end
        end
        req0_d = 1'b0;
        req1_d = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*DW+AW+4:0] va, vb;
        va = {bus_a.ack0, bus_a.ack1, bus_a.busy, bus_a.mem_write, bus_a.mem_read,
              bus_a.mem_addr, bus_a.mem_wdata, bus_a.rdata};
        vb = {bus_b.ack0, bus_b.ack1, bus_b.busy, bus_b.mem_write, bus_b.mem_read,
              bus_b.mem_addr, bus_b.mem_wdata, bus_b.rdata};
        tests++;
        if (va !== '0) begin
            fails++; $display("FAIL reset_a: outputs=%h required 0", va);
        end
        tests++;
        if (vb !== '0) begin
            fails++; $display("FAIL reset_b: outputs=%h required 0", vb);
        end
    endtask

    task automatic test_write();
        run_txn(1'b0, 1'b1, 4'd3, 8'hA5);
        tests++;
        if (r_ack !== 2 || r_stray) begin
            fails++; $display("FAIL write_ack: ack cycle %0d stray %0d, required 2 and 0", r_ack, r_stray);
        end
        tests++;
        if (r_wmask !== 32'h2 || r_rmask !== 0 || !r_busok) begin
            fails++; $display("FAIL write_bus: wmask %h rmask %h busok %0d, required 2 0 1", r_wmask, r_rmask, r_busok);
        end
        tests++;
        if (r_bmask !== 32'h6) begin
            fails++; $display("FAIL write_busy: busy mask %h, required 6", r_bmask);
        end
        model_commit(1'b0, 1'b1, 4'd3, 8'hA5);
    endtask

    task automatic test_read();
        run_txn(1'b1, 1'b0, 4'd3, 8'h00);
        tests++;
        if (r_ack !== 4 || r_rmask !== 32'he || r_wmask !== 0 || !r_busok || r_stray) begin
            fails++; $display("FAIL read_timing: ack %0d rmask %h wmask %h busok %0d stray %0d, required 4 e 0 1 0",
                              r_ack, r_rmask, r_wmask, r_busok, r_stray);
        end
        tests++;
        if (r_rd !== ref_mem[0][3]) begin
            fails++; $display("FAIL read_data: rdata %h, required %h", r_rd, ref_mem[0][3]);
        end
        model_commit(1'b1, 1'b0, 4'd3, 8'h00);
        run_txn(1'b1, 1'b1, 4'd7, 8'h3C);
        model_commit(1'b1, 1'b1, 4'd7, 8'h3C);
        tests++;
        if (o_rdata !== ref_rdata[0] || r_rd !== ref_rdata[0]) begin
            fails++; $display("FAIL read_hold: rdata %h / %h after write, required %h", r_rd, o_rdata, ref_rdata[0]);
        end
    endtask

    task automatic test_random(input int n);
        logic          port, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data, exp_rd;
        int            l;
        l = lat_of(sel);
        for (int i = 0; i < n; i++) begin
            port = 1'($urandom); we = 1'($urandom);
            addr = AW'($urandom); data = DW'($urandom);
            exp_rd = we ? ref_rdata[sel] : ref_mem[sel][addr];
            run_txn(port, we, addr, data);
            tests++;
            if (r_ack !== exp_ack(we, l) || r_wmask !== exp_wmask(we) || r_rmask !== exp_rmask(we, l) ||
                r_bmask !== exp_bmask(we, l) || !r_busok || r_stray) begin
                fails++;
                $display("FAIL rand_timing[%0d]: port %0d we %0d ack %0d w %h r %h b %h ok %0d stray %0d, required ack %0d w %h r %h b %h",
                         i, port, we, r_ack, r_wmask, r_rmask, r_bmask, r_busok, r_stray,
                         exp_ack(we, l), exp_wmask(we), exp_rmask(we, l), exp_bmask(we, l));
            end
            tests++;
            if (r_rd !== exp_rd) begin
                fails++; $display("FAIL rand_data[%0d]: rdata %h, required %h", i, r_rd, exp_rd);
            end
            model_commit(port, we, addr, data);
        end
    endtask

    task automatic test_contention(input int n);
        logic [AW-1:0] a0, a1;
        int            l, exp_port;
        logic [DW-1:0] exp_rd;
        l = lat_of(sel);
        a0 = AW'($urandom); a1 = AW'($urandom);
        run_both(n, a0, a1);
        tests++;
        if (c_cnt !== n || c_overlap) begin
            fails++; $display("FAIL cont_count: acks %0d overlap %0d, required %0d and 0", c_cnt, c_overlap, n);
        end
        for (int i = 0; i < c_cnt; i++) begin
            exp_port = (model_last[sel] == 1'b1) ? 0 : 1;
            exp_rd = ref_mem[sel][exp_port ? a1 : a0];
            tests++;
            if (c_port[i] !== exp_port || c_cyc[i] !== 2 + l + i * (3 + l) || c_rd[i] !== exp_rd) begin
                fails++;
                $display("FAIL cont_txn[%0d]: port %0d cycle %0d rdata %h, required %0d %0d %h",
                         i, c_port[i], c_cyc[i], c_rd[i], exp_port, 2 + l + i * (3 + l), exp_rd);
            end
            model_commit(exp_port[0], 1'b0, exp_port ? a1 : a0, '0);
        end
    endtask

    task automatic test_boundary();
        logic [AW-1:0] wa [4];
        logic [DW-1:0] wd [4];
        logic [AW-1:0] ra [4];
        wa[0] = 4'd14; wd[0] = 8'h11;
        wa[1] = 4'd1;  wd[1] = 8'h22;
        wa[2] = 4'd15; wd[2] = 8'h00;
        wa[3] = 4'd0;  wd[3] = 8'hFF;
        ra[0] = 4'd15; ra[1] = 4'd0; ra[2] = 4'd14; ra[3] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, 1'b1, wa[i], wd[i]);
            model_commit(1'b0, 1'b1, wa[i], wd[i]);
        end
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b0, ra[i], '0);
            tests++;
            if (r_rd !== ref_mem[sel][ra[i]] || !r_busok || r_ack !== exp_ack(1'b0, lat_of(sel))) begin
                fails++; $display("FAIL boundary[%0d]: addr %0d rdata %h busok %0d ack %0d, required %h 1 %0d",
                                  i, ra[i], r_rd, r_busok, r_ack, ref_mem[sel][ra[i]], exp_ack(1'b0, lat_of(sel)));
            end
            model_commit(1'b1, 1'b0, ra[i], '0);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*DW+AW+4:0] va;
        logic           seen_ack;
        run_txn(1'b0, 1'b1, 4'd9, 8'h5A);
        model_commit(1'b0, 1'b1, 4'd9, 8'h5A);
        req0_d = 1'b1; we0_d = 1'b0; addr0_d = 4'd9;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        va = {bus_a.ack0, bus_a.ack1, bus_a.busy, bus_a.mem_write, bus_a.mem_read,
              bus_a.mem_addr, bus_a.mem_wdata, bus_a.rdata};
        tests++;
        if (va !== '0) begin
            fails++; $display("FAIL reset_async: outputs=%h right after rst rose, required 0", va);
        end
        req0_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model_last[i] = 1'b1;
            ref_rdata[i] = '0;
        end
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_ack0 || o_ack1 || o_busy) seen_ack = 1'b1;
        end
        tests++;
        if (seen_ack) begin
            fails++; $display("FAIL reset_abort: ack or busy seen after aborted read, required none");
        end
        test_contention(2);
        run_txn(1'b1, 1'b0, 4'd9, '0);
        tests++;
        if (r_ack !== exp_ack(1'b0, lat_of(sel)) || r_rmask[1] !== 1'b1 || r_rd !== ref_mem[sel][9]) begin
            fails++; $display("FAIL reset_regrant: ack %0d rmask %h rdata %h, required %0d bit1 set %h",
                              r_ack, r_rmask, r_rd, exp_ack(1'b0, lat_of(sel)), ref_mem[sel][9]);
        end
        model_commit(1'b1, 1'b0, 4'd9, '0);
    endtask

    task automatic test_lat1();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        sel = 1'b1;
        @(negedge clk);
        a = AW'($urandom); d = DW'($urandom);
        run_txn(1'b0, 1'b1, a, d);
        model_commit(1'b0, 1'b1, a, d);
        run_txn(1'b1, 1'b0, a, '0);
        tests++;
        if (r_ack !== 3 || r_rmask !== 32'h6 || !r_busok || r_rd !== d) begin
            fails++; $display("FAIL lat1_read: ack %0d rmask %h busok %0d rdata %h, required 3 6 1 %h",
                              r_ack, r_rmask, r_busok, r_rd, d);
        end
        model_commit(1'b1, 1'b0, a, '0);
        test_random(8);
        test_contention(4);
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; sel = 1'b0;
        req0_d = 1'b0; we0_d = 1'b0; addr0_d = '0; wdata0_d = '0;
        req1_d = 1'b0; we1_d = 1'b0; addr1_d = '0; wdata1_d = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) ref_mem[i][j] = '0;
            ref_rdata[i] = '0;
            model_last[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        test_reset();
        mem_clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        test_write();
        test_read();
        test_contention(4);
        test_random(24);
        test_boundary();
        test_contention(3);
        test_reset_mid();
        test_lat1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
